// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity modes and parity helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Expected parity bit for a zero-padded word; callers pass the unused upper bits as 0.
    function automatic logic parity_calc(input logic [15:0] word, input int mode);
        logic p;
        p = ^word;
        if (mode == PAR_ODD) begin
            p = ~p;
        end else if (mode != PAR_EVEN) begin
            p = 1'b0;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for asynchronous single-bit inputs
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - parametrised mid-bit sampling UART receiver with
// one-entry output buffer and parity / framing / overrun flags
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              u_rx,
    input  logic              en_rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    rx_state_t          state, state_nx;
    logic               rxs, rxs_d;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               stop_idx;
    logic [DATA_W-1:0]  shreg;
    logic               par_bad, stop_bad;
    logic               tick, stop_last;
    logic               done, perr_fin, ferr_fin, good, load, ovr_fire;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (u_rx),
        .q     (rxs)
    );

    // START waits half a bit to land mid-bit; every later sample is a full bit apart.
    assign tick      = (state == ST_START) ? (cnt == HALF_END) : (cnt == FULL_END);
    assign stop_last = (STOP_BITS == 1) || stop_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (state != ST_IDLE && !en_rx) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en_rx && rxs_d && !rxs) state_nx = ST_START;
                end
                ST_START: begin
                    if (tick) state_nx = rxs ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (tick && idx == IDX_LAST) begin
                        state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (tick) state_nx = ST_STOP;
                end
                ST_STOP: begin
                    if (tick && stop_last) state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        done     = en_rx && (state == ST_STOP) && tick && stop_last;
        perr_fin = par_bad;
        ferr_fin = stop_bad || !rxs;
        good     = done && !perr_fin && !ferr_fin;
        load     = good && (!valid || ready);
        ovr_fire = good && valid && !ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxs_d    <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
        end else begin
            rxs_d <= rxs;
            if (state == ST_IDLE || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (state == ST_START) begin
                idx      <= '0;
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
            end
            if (state == ST_DATA && tick) begin
                idx   <= idx + IDX_W'(1);
                shreg <= {rxs, shreg[DATA_W-1:1]};
            end
            if (state == ST_PARITY && tick) begin
                par_bad <= (rxs != parity_calc(16'(shreg), PARITY));
            end
            if (state != ST_STOP) begin
                stop_idx <= 1'b0;
            end else if (tick) begin
                stop_idx <= 1'b1;
                stop_bad <= stop_bad || !rxs;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= done && perr_fin;
            frame_err  <= done && ferr_fin;
            overrun    <= ovr_fire;
            if (load) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core (default and 7O2 instances)
module tb_uart_rx_core;

    localparam int CPB     = 16;
    localparam int EV_DATA = 0;
    localparam int EV_PERR = 1;
    localparam int EV_FERR = 2;
    localparam int EV_OVR  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_rx = 1'b1;
    logic       rx_a = 1'b1, rx_b = 1'b1;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a;
    logic       valid_b, perr_b, ferr_b, ovr_b;

    always #5 clk = ~clk;

    uart_rx_core dut_a (
        .clk (clk), .rst_n (rst_n), .u_rx (rx_a), .en_rx (en_rx),
        .data (data_a), .valid (valid_a), .ready (ready_a),
        .parity_err (perr_a), .frame_err (ferr_a), .overrun (ovr_a)
    );

    uart_rx_core #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk (clk), .rst_n (rst_n), .u_rx (rx_b), .en_rx (en_rx),
        .data (data_b), .valid (valid_b), .ready (ready_b),
        .parity_err (perr_b), .frame_err (ferr_b), .overrun (ovr_b)
    );

    typedef struct {
        int         kind;
        logic [8:0] word;
    } ev_t;

    typedef struct {
        logic [7:0] word;
        logic       flip;
        logic       stop;
        logic       perr;
        logic       ferr;
    } vec_t;

    ev_t  q_a[$], q_b[$];
    vec_t vecs[8];
    int   checks = 0, failures = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int sel, input int kind, input logic [8:0] word);
        ev_t e;
        e.kind = kind;
        e.word = word;
        if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    task automatic see_event(input int sel, input int kind, input logic [8:0] word);
        ev_t e;
        int  depth;
        checks++;
        depth = (sel == 0) ? q_a.size() : q_b.size();
        if (depth == 0) begin
            failures++;
            $display("FAIL unexpected_event dut=%0d: got kind=%0d word=%0h expected none", sel, kind, word);
        end else begin
            if (sel == 0) e = q_a.pop_front(); else e = q_b.pop_front();
            if (e.kind != kind || (kind == EV_DATA && e.word !== word)) begin
                failures++;
                $display("FAIL event dut=%0d: got kind=%0d word=%0h expected kind=%0d word=%0h",
                         sel, kind, word, e.kind, e.word);
            end
        end
    endtask

    initial begin : mon_a
        forever begin
            @(posedge clk);
            #1;
            if (valid_a && !prev_a) see_event(0, EV_DATA, {1'b0, data_a});
            if (perr_a) see_event(0, EV_PERR, 9'h0);
            if (ferr_a) see_event(0, EV_FERR, 9'h0);
            if (ovr_a)  see_event(0, EV_OVR, 9'h0);
            prev_a = valid_a;
        end
    end

    initial begin : mon_b
        forever begin
            @(posedge clk);
            #1;
            if (valid_b && !prev_b) see_event(1, EV_DATA, {2'b0, data_b});
            if (perr_b) see_event(1, EV_PERR, 9'h0);
            if (ferr_b) see_event(1, EV_FERR, 9'h0);
            if (ovr_b)  see_event(1, EV_OVR, 9'h0);
            prev_b = valid_b;
        end
    end

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) rx_a = b; else rx_b = b;
    endtask

    task automatic hold_bit(input int sel, input logic b);
        set_line(sel, b);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Leaves the line at the last stop level so callers can model a break.
    task automatic send_frame(input int sel, input logic [8:0] word, input int nbits, input int pmode,
                              input logic flip, input logic stop1, input logic stop2, input int nstop);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ word[i];
        if (pmode == 2) p = ~p;
        hold_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(sel, word[i]);
        if (pmode != 0) hold_bit(sel, p ^ flip);
        hold_bit(sel, stop1);
        if (nstop == 2) hold_bit(sel, stop2);
    endtask

    task automatic wait_drain(input int sel, input string name);
        int n;
        n = 0;
        while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s: got %0d pending events expected 0", name,
                     (sel == 0) ? q_a.size() : q_b.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int         lat;
        logic [7:0] last_a;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b0};

        #2;
        check("reset_data_a", {24'h0, data_a}, 32'h0);
        check("reset_flags_a", {28'h0, valid_a, perr_a, ferr_a, ovr_a}, 32'h0);
        check("reset_data_b", {25'h0, data_b}, 32'h0);
        check("reset_flags_b", {28'h0, valid_b, perr_b, ferr_b, ovr_b}, 32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Good frame: latency from the start edge and single-cycle valid with ready=1.
        push(0, EV_DATA, 9'h0A5);
        fork
            send_frame(0, 9'h0A5, 8, 1, 1'b0, 1'b1, 1'b1, 1);
            begin
                lat = 0;
                while (!valid_a && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check("good_latency", lat, 171);
                check("good_data", {24'h0, data_a}, 32'hA5);
                check("good_flags", {29'h0, perr_a, ferr_a, ovr_a}, 32'h0);
                @(posedge clk);
                #1;
                check("good_valid_drop", {31'h0, valid_a}, 32'h0);
                check("good_data_hold", {24'h0, data_a}, 32'hA5);
            end
        join
        set_line(0, 1'b1);
        wait_drain(0, "good_drain");
        idle(10);

        last_a = 8'hA5;
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].perr) push(0, EV_PERR, 9'h0);
            if (vecs[v].ferr) push(0, EV_FERR, 9'h0);
            if (!vecs[v].perr && !vecs[v].ferr) begin
                push(0, EV_DATA, {1'b0, vecs[v].word});
                last_a = vecs[v].word;
            end
            send_frame(0, {1'b0, vecs[v].word}, 8, 1, vecs[v].flip, vecs[v].stop, 1'b1, 1);
            set_line(0, 1'b1);
            wait_drain(0, "vec_drain");
            check("vec_valid_idle", {31'h0, valid_a}, 32'h0);
            check("vec_data_held", {24'h0, data_a}, {24'h0, last_a});
            idle(10);
        end

        // Break: frame with stop 0 then the line stays low.
        push(0, EV_FERR, 9'h0);
        send_frame(0, 9'h055, 8, 1, 1'b0, 1'b0, 1'b1, 1);
        idle(400);
        set_line(0, 1'b1);
        idle(20);
        wait_drain(0, "break_drain");
        check("break_valid", {31'h0, valid_a}, 32'h0);

        // Glitch shorter than half a bit, then a normal frame.
        set_line(0, 1'b0);
        idle(5);
        set_line(0, 1'b1);
        idle(40);
        check("glitch_valid", {31'h0, valid_a}, 32'h0);
        check("glitch_data", {24'h0, data_a}, {24'h0, last_a});
        push(0, EV_DATA, 9'h00F);
        send_frame(0, 9'h00F, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        set_line(0, 1'b1);
        wait_drain(0, "glitch_frame_drain");
        idle(10);

        // Overrun with back-to-back frames.
        ready_a = 1'b0;
        push(0, EV_DATA, 9'h011);
        push(0, EV_OVR, 9'h0);
        send_frame(0, 9'h011, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        send_frame(0, 9'h022, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        set_line(0, 1'b1);
        wait_drain(0, "overrun_drain");
        check("overrun_valid", {31'h0, valid_a}, 32'h1);
        check("overrun_data", {24'h0, data_a}, 32'h11);
        ready_a = 1'b1;
        idle(1);
        check("overrun_release", {31'h0, valid_a}, 32'h0);
        idle(10);

        // Disable mid-frame: aborted silently.
        fork
            send_frame(0, 9'h033, 8, 1, 1'b0, 1'b1, 1'b1, 1);
            begin
                idle(40);
                en_rx = 1'b0;
            end
        join
        set_line(0, 1'b1);
        idle(5);
        en_rx = 1'b1;
        idle(30);
        check("abort_valid", {31'h0, valid_a}, 32'h0);
        check("abort_data", {24'h0, data_a}, 32'h11);

        // Reset at bit 3 with a word parked in the buffer.
        ready_a = 1'b0;
        push(0, EV_DATA, 9'h0C3);
        send_frame(0, 9'h0C3, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        set_line(0, 1'b1);
        wait_drain(0, "pre_reset_drain");
        check("pre_reset_valid", {31'h0, valid_a}, 32'h1);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b0);
        set_line(0, 1'b1);
        idle(8);
        rst_n = 1'b0;
        #1;
        check("midreset_data_a", {24'h0, data_a}, 32'h0);
        check("midreset_flags_a", {28'h0, valid_a, perr_a, ferr_a, ovr_a}, 32'h0);
        check("midreset_b", {24'h0, valid_b, data_b}, 32'h0);
        idle(5);
        rst_n = 1'b1;
        ready_a = 1'b1;
        idle(5);
        push(0, EV_DATA, 9'h096);
        send_frame(0, 9'h096, 8, 1, 1'b0, 1'b1, 1'b1, 1);
        set_line(0, 1'b1);
        wait_drain(0, "post_reset_drain");
        check("post_reset_data", {24'h0, data_a}, 32'h96);

        // 7 data bits, odd parity, two stop bits.
        push(1, EV_DATA, 9'h07F);
        send_frame(1, 9'h07F, 7, 2, 1'b0, 1'b1, 1'b1, 2);
        set_line(1, 1'b1);
        wait_drain(1, "b_good_drain");
        check("b_good_data", {25'h0, data_b}, 32'h7F);
        idle(10);
        push(1, EV_FERR, 9'h0);
        send_frame(1, 9'h02A, 7, 2, 1'b0, 1'b1, 1'b0, 2);
        set_line(1, 1'b1);
        wait_drain(1, "b_stop2_drain");
        idle(10);
        push(1, EV_PERR, 9'h0);
        send_frame(1, 9'h015, 7, 2, 1'b1, 1'b1, 1'b1, 2);
        set_line(1, 1'b1);
        wait_drain(1, "b_parity_drain");
        idle(10);
        push(1, EV_DATA, 9'h015);
        send_frame(1, 9'h015, 7, 2, 1'b0, 1'b1, 1'b1, 2);
        set_line(1, 1'b1);
        wait_drain(1, "b_good2_drain");
        check("b_good2_data", {25'h0, data_b}, 32'h15);
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
